// File: rtl/cam_frame_writer_if.sv
// Camera parallel bus plus the memory write port driven by cam_frame_writer.
// master: the frame writer (samples camera, drives memory write).
// slave : the camera source / memory side.
interface cam_frame_writer_if #(
    parameter int ADDR_W = 20
);
    logic              cam_pclk;
    logic              cam_href;
    logic              cam_vsync;
    logic [7:0]        cam_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        input  cam_pclk, cam_href, cam_vsync, cam_data,
        output mem_we, mem_addr, mem_data
    );

    modport slave (
        output cam_pclk, cam_href, cam_vsync, cam_data,
        input  mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/cam_frame_writer.sv
// Camera capture into the frame buffer write port. Camera signals are
// synchronized into CLOCK_50 and edge-detected; one byte of each two-byte
// pixel is stored row-major. Camera is expected to change href/data while
// pclk is low, so an href edge and a pclk rise never share an event cycle.
module cam_frame_writer #(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int ADDR_W      = 20,
    parameter int SYNC_STAGES = 2,
    parameter int BYTE_SEL    = 0,
    parameter int VSYNC_POL   = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  capture_en,
    cam_frame_writer_if.master    bus,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic [9:0]            line_count,
    output logic                  overflow
);
    localparam int unsigned       COL_W   = $clog2(H_PIXELS + 1);
    localparam logic [COL_W-1:0]  COL_MAX = COL_W'(H_PIXELS);
    localparam logic [ADDR_W-1:0] H_STEP  = ADDR_W'(H_PIXELS);
    localparam logic [9:0]        V_MAX   = 10'(V_LINES);
    localparam logic              BSEL    = (BYTE_SEL != 0);
    localparam logic              VS_ACT  = (VSYNC_POL != 0);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    // synchronizer chains (all equal depth so data stays aligned with pclk)
    logic [SYNC_STAGES-1:0] pclk_sync, href_sync, vsync_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   pclk_prev, href_prev;

    // registered camera events
    logic                   ev_pclk_rise, ev_href, ev_href_rise, ev_href_fall, ev_vs_active;
    logic [7:0]             ev_data;

    // capture state
    state_t                 state;
    logic                   seen_vs;
    logic                   phase;
    logic [COL_W-1:0]       column;
    logic [ADDR_W-1:0]      addr, row_base;
    logic                   wr_pend;
    logic [ADDR_W-1:0]      wr_addr;
    logic [7:0]             wr_data;

    // Shift camera inputs through the synchronizer chains.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pclk_sync  <= '0;
            href_sync  <= '0;
            vsync_sync <= '0;
            pclk_prev  <= 1'b0;
            href_prev  <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            pclk_sync    <= {pclk_sync[SYNC_STAGES-2:0], bus.cam_pclk};
            href_sync    <= {href_sync[SYNC_STAGES-2:0], bus.cam_href};
            vsync_sync   <= {vsync_sync[SYNC_STAGES-2:0], bus.cam_vsync};
            data_sync[0] <= bus.cam_data;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            pclk_prev    <= pclk_sync[SYNC_STAGES-1];
            href_prev    <= href_sync[SYNC_STAGES-1];
        end
    end

    // Register edge events together with the href level and data of the same stage.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ev_pclk_rise <= 1'b0;
            ev_href      <= 1'b0;
            ev_href_rise <= 1'b0;
            ev_href_fall <= 1'b0;
            ev_vs_active <= 1'b0;
            ev_data      <= '0;
        end else begin
            ev_pclk_rise <= pclk_sync[SYNC_STAGES-1] & ~pclk_prev;
            ev_href      <= href_sync[SYNC_STAGES-1];
            ev_href_rise <= href_sync[SYNC_STAGES-1] & ~href_prev;
            ev_href_fall <= ~href_sync[SYNC_STAGES-1] & href_prev;
            ev_vs_active <= (vsync_sync[SYNC_STAGES-1] == VS_ACT);
            ev_data      <= data_sync[SYNC_STAGES-1];
        end
    end

    // Frame FSM: tracks vsync/href, byte phase, column/row addressing and overflow.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            seen_vs      <= 1'b0;
            phase        <= 1'b0;
            column       <= '0;
            addr         <= '0;
            row_base     <= '0;
            wr_pend      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            line_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            wr_pend    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    frame_active <= 1'b0;
                    seen_vs      <= 1'b0;
                    if (capture_en) state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (ev_vs_active) begin
                        seen_vs <= 1'b1;
                    end else if (seen_vs) begin
                        seen_vs      <= 1'b0;
                        addr         <= '0;
                        row_base     <= '0;
                        column       <= '0;
                        phase        <= 1'b0;
                        line_count   <= '0;
                        overflow     <= 1'b0;
                        frame_active <= 1'b1;
                        state        <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (ev_vs_active) begin
                        frame_done   <= 1'b1;
                        frame_active <= 1'b0;
                        state        <= DONE;
                    end else if (ev_href_rise) begin
                        phase  <= 1'b0;
                        column <= '0;
                        addr   <= row_base;
                    end else if (ev_href_fall) begin
                        // an unpaired trailing byte is simply abandoned here
                        phase  <= 1'b0;
                        column <= '0;
                        if (line_count < V_MAX) begin
                            row_base   <= row_base + H_STEP;
                            line_count <= line_count + 10'd1;
                        end
                    end else if (ev_pclk_rise && ev_href) begin
                        phase <= ~phase;
                        if (line_count >= V_MAX) begin
                            overflow <= 1'b1;
                        end else if (phase == BSEL) begin
                            if (column >= COL_MAX) begin
                                overflow <= 1'b1;
                            end else begin
                                wr_pend <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= ev_data;
                                addr    <= addr + ADDR_W'(1);
                                column  <= column + COL_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    seen_vs <= 1'b0;
                    state   <= capture_en ? WAIT_VS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory write port register; address/data hold their last written value.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
        end else begin
            bus.mem_we <= wr_pend;
            if (wr_pend) begin
                bus.mem_addr <= wr_addr;
                bus.mem_data <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: two instances (BYTE_SEL 0 and 1) share one
// camera stimulus; expected writes are queued per instance and popped by
// a monitor whenever mem_we is seen.
module tb_cam_frame_writer;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 4;
    localparam int SS = 2;

    logic       clk = 1'b0, rst_n = 1'b0, cap_en = 1'b0;
    logic       pclk = 1'b0, href = 1'b0, vsync = 1'b0;
    logic [7:0] data = 8'h00;

    always #10 clk = ~clk;

    cam_frame_writer_if #(.ADDR_W(AW)) if0 ();
    cam_frame_writer_if #(.ADDR_W(AW)) if1 ();

    assign if0.cam_pclk = pclk;  assign if1.cam_pclk = pclk;
    assign if0.cam_href = href;  assign if1.cam_href = href;
    assign if0.cam_vsync = vsync; assign if1.cam_vsync = vsync;
    assign if0.cam_data = data;  assign if1.cam_data = data;

    logic       fa0, fd0, ov0, fa1, fd1, ov1;
    logic [9:0] lc0, lc1;

    cam_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .SYNC_STAGES(SS),
                       .BYTE_SEL(0), .VSYNC_POL(1)) dut0 (
        .CLOCK_50(clk), .reset_n(rst_n), .capture_en(cap_en), .bus(if0),
        .frame_active(fa0), .frame_done(fd0), .line_count(lc0), .overflow(ov0));

    cam_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .SYNC_STAGES(SS),
                       .BYTE_SEL(1), .VSYNC_POL(1)) dut1 (
        .CLOCK_50(clk), .reset_n(rst_n), .capture_en(cap_en), .bus(if1),
        .frame_active(fa1), .frame_done(fd1), .line_count(lc1), .overflow(ov1));

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        q0[$], q1[$];
    int         errors = 0, checks = 0;
    int         done0 = 0, done1 = 0;
    logic [9:0] lc_snap0 = '0, lc_snap1 = '0;
    logic       ov_snap0 = 1'b0, ov_snap1 = 1'b0;
    int         cyc = 0, lat_e0 = 0;
    bit         lat_arm = 1'b0, lat_wait = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every write strobe, snapshot status on frame_done.
    always @(negedge clk) begin
        wr_t got, exp;
        if (if0.mem_we) begin
            got = {if0.mem_addr, if0.mem_data};
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL write0: unexpected write addr=%0d data=%h", got.addr, got.data);
            end else begin
                exp = q0.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL write0: got addr=%0d data=%h expected addr=%0d data=%h",
                             got.addr, got.data, exp.addr, exp.data);
                end
            end
            if (lat_wait) begin
                lat_wait = 1'b0;
                check("latency", cyc - lat_e0, SS + 2);
            end
        end
        if (if1.mem_we) begin
            got = {if1.mem_addr, if1.mem_data};
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL write1: unexpected write addr=%0d data=%h", got.addr, got.data);
            end else begin
                exp = q1.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL write1: got addr=%0d data=%h expected addr=%0d data=%h",
                             got.addr, got.data, exp.addr, exp.data);
                end
            end
        end
        if (fd0) begin done0++; lc_snap0 = lc0; ov_snap0 = ov0; end
        if (fd1) begin done1++; lc_snap1 = lc1; ov_snap1 = ov1; end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte: pclk low for two cycles with data set, then high for two.
    task automatic send_byte(logic [7:0] b);
        @(negedge clk); data = b; pclk = 1'b0;
        @(negedge clk);
        @(negedge clk); pclk = 1'b1;
        if (lat_arm) begin
            lat_e0   = cyc + 1;
            lat_arm  = 1'b0;
            lat_wait = 1'b1;
        end
        @(negedge clk);
    endtask

    // A line of bytes base, base+1, ...; queues the expected stored bytes.
    task automatic send_line(logic [7:0] base, int nbytes, bit expect_wr, int row);
        for (int p = 0; p < nbytes / 2; p++) begin
            if (expect_wr && p < H) begin
                q0.push_back('{addr: AW'(row * H + p), data: base + 8'(2 * p)});
                q1.push_back('{addr: AW'(row * H + p), data: base + 8'(2 * p + 1)});
            end
        end
        @(negedge clk); href = 1'b1; pclk = 1'b0;
        for (int i = 0; i < nbytes; i++) send_byte(base + 8'(i));
        @(negedge clk); pclk = 1'b0; href = 1'b0;
        idle(4);
    endtask

    task automatic pulse_vsync();
        @(negedge clk); vsync = 1'b1;
        idle(6);
        vsync = 1'b0;
        idle(8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        idle(3);
        check("rst_mem_we", int'(if0.mem_we), 0);
        check("rst_mem_addr", int'(if0.mem_addr), 0);
        check("rst_line_count", int'(lc0), 0);
        check("rst_frame_active", int'(fa0), 0);
        check("rst_overflow", int'(ov0), 0);
        check("rst_frame_done", int'(fd0), 0);
        rst_n = 1'b1;
        idle(2);
        cap_en = 1'b1;
        idle(2);

        // frame 1: plain 4x2, latency measured on the first byte
        pulse_vsync();
        lat_arm = 1'b1;
        send_line(8'h10, 8, 1'b1, 0);
        check("frame_active_in_capture", int'(fa0), 1);
        send_line(8'h18, 8, 1'b1, 1);
        pulse_vsync();
        check("f1_done0", done0, 1);
        check("f1_done1", done1, 1);
        check("f1_line_count", int'(lc_snap0), 2);
        check("f1_overflow", int'(ov_snap0), 0);
        check("f1_overflow1", int'(ov_snap1), 0);

        // frame 2: first line 6 pixels, two dropped
        send_line(8'h20, 12, 1'b1, 0);
        send_line(8'h30, 8, 1'b1, 1);
        pulse_vsync();
        check("f2_done0", done0, 2);
        check("f2_line_count", int'(lc_snap0), 2);
        check("f2_overflow0", int'(ov_snap0), 1);
        check("f2_overflow1", int'(ov_snap1), 1);

        // frame 3: capture_en dropped mid-frame, frame still completes
        send_line(8'h40, 8, 1'b1, 0);
        cap_en = 1'b0;
        send_line(8'h48, 8, 1'b1, 1);
        pulse_vsync();
        check("f3_done0", done0, 3);
        check("f3_overflow", int'(ov_snap0), 0);

        // frame 4: idle, no writes
        send_line(8'h50, 8, 1'b0, 0);
        check("f4_frame_active", int'(fa0), 0);
        send_line(8'h58, 8, 1'b0, 1);
        idle(4);
        check("f4_done0", done0, 3);

        // frame 5: reset between lines
        cap_en = 1'b1;
        idle(2);
        pulse_vsync();
        send_line(8'h60, 8, 1'b1, 0);
        idle(8);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("mid_rst_mem_we", int'(if0.mem_we), 0);
        check("mid_rst_mem_addr", int'(if0.mem_addr), 0);
        check("mid_rst_line_count", int'(lc0), 0);
        check("mid_rst_frame_active", int'(fa0), 0);
        idle(3);
        rst_n = 1'b1;
        send_line(8'h68, 8, 1'b0, 1);
        pulse_vsync();
        check("f5_no_done", done0, 3);

        // frame 6: recovery after reset
        send_line(8'h70, 8, 1'b1, 0);
        send_line(8'h78, 8, 1'b1, 1);
        pulse_vsync();
        check("f6_done0", done0, 4);
        check("f6_done1", done1, 4);
        check("f6_line_count", int'(lc_snap1), 2);
        check("f6_overflow", int'(ov_snap0), 0);

        idle(10);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("latency_seen", int'(lat_wait), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
